hart_slot_arbiter: RTL and testbench
====================================

# hart_slot_arbiter

Time-multiplexing arbiter that shares one memory/MMU port among `N_HARTS` pipelined cores in a cluster. It is the parametrised successor to the cluster's fixed round-robin hart selector. It adds:
- a quantum (timeslice) mode,
- skipping of idle harts,
- an atomic/CSR lock,
- an explicit one-cycle switch bubble.

It sits between the per-hart core/MMU instances and the shared bus, memory controller and DRAM path.

## Interface
Parameters:
- `N_HARTS`, 2, number of harts; legal range 1..16.
- `PAYLOAD_W`, 128, width of one hart's flattened request bundle (addresses, wdata, ctrl, TLB fields).
- `QUANTUM`, 0, cycles per timeslice; 0 = switch at every eligible yield.
- `SKIP_IDLE`, 1, 1 = round-robin skips harts with `w_hart_active` low.
- Derived: `SEL_W` = max(1, clog2(`N_HARTS`)); `QW` = max(1, clog2(`QUANTUM`+1)).

Ports:
- `CLK` in 1: sole clock.
- `RST` in 1: reset. Synchronous, active-high.
- `w_hart_active` in `N_HARTS`: hart has work (not halted, not WFI).
- `w_hart_yield` in `N_HARTS`: hart is at a safe boundary (pipeline next-state idle and taken branch).
- `w_hart_lock` in `N_HARTS`: CSR op or LR/SC sequence in flight; forbids switching away from this hart.
- `w_busy` in 1: shared memory port busy.
- `w_dram_busy` in 1: DRAM/page-walk busy.
- `w_hart_payload` in `N_HARTS`*`PAYLOAD_W`: hart g occupies bits [g*`PAYLOAD_W` +: `PAYLOAD_W`].
- `w_cluster_payload` out `PAYLOAD_W`: payload of the selected hart (combinational mux on `r_hart_sel`).
- `w_core_busy` out `N_HARTS`: `w_busy` for the granted hart; 1 for all others.
- `w_core_dram_busy` out `N_HARTS`: same rule, driven from `w_dram_busy`.
- `r_hart_sel` out `SEL_W`: selected hart index.
- `r_grant` out `N_HARTS`: one-hot form of `r_hart_sel`.
- `r_switch` out 1: high during the SWITCH bubble cycle.
- `r_slice_cnt` out `QW`: cycles elapsed in the current slice.

## Operation
- States: RUN, DRAIN, SWITCH.
- `can_go` = !`w_hart_lock`[sel] && !`w_busy` && !`w_dram_busy`.
- `nxt` = first index after sel, cyclically, whose `w_hart_active` is high (when `SKIP_IDLE`=1); otherwise sel+1 mod `N_HARTS`.
  - `nxt_valid` is true when `nxt` != sel.
  - With `SKIP_IDLE`=1 and no other active hart, `nxt_valid` is false.
- RUN:
  - Quantum counting (`QUANTUM`>0): `r_slice_cnt` increments each cycle and saturates at `QUANTUM`.
  - Switch-eligible event:
    - `QUANTUM`=0: `w_hart_yield`[sel].
    - `QUANTUM`>0: `w_hart_yield`[sel] && `r_slice_cnt`>=`QUANTUM`.
  - Leaving RUN because the slice has expired but the yield has not arrived yet: go to DRAIN.
- DRAIN: hold until `w_hart_yield`[sel]; the counter stays saturated.
- Switch rule, in RUN or DRAIN:
  - Fire when (eligible event, or `w_hart_active`[sel] low) && `can_go` && `nxt_valid`.
  - On fire: `r_hart_sel` <= `nxt`, `r_grant` updates, go to SWITCH.
- Eligible but no valid `nxt`: stay on the current hart, clear `r_slice_cnt`, return to RUN.
- SWITCH: exactly one cycle.
  - All `w_core_busy` and `w_core_dram_busy` bits are 1.
  - `r_switch`=1.
  - Next cycle: RUN with `r_slice_cnt`=0.
- Precedence:
  - Lock beats yield, quantum expiry and inactivity.
  - `w_busy`/`w_dram_busy` high defers the switch and never drops it.
  - DRAIN persists until the switch fires.
- `N_HARTS`=1: `r_hart_sel` is always 0 and SWITCH is never entered.
- Payload mux, `w_core_busy` and `w_core_dram_busy` are combinational from the registered select and state.

## Timing
- Reset values: `r_hart_sel`=0, `r_grant`=1, state RUN, `r_slice_cnt`=0, `r_switch`=0.
- `RST` asserted mid-SWITCH or mid-DRAIN returns all of the above to reset values on the next edge.
- Switch latency: the qualifying cycle at edge k gives the new `r_hart_sel` and `r_switch`=1 after edge k.
  - The new hart sees `w_core_busy` = `w_busy` after edge k+1.
- The old hart sees `w_core_busy`=1 from after edge k onward.
- At most one switch per 2 cycles.
- No combinational path from `w_hart_payload` to any registered output.

## Test plan
- Basic round robin: `N_HARTS`=2, `QUANTUM`=0, both active, yield pulses on hart 0 with `w_busy`=0.
  - Required: `r_hart_sel` 0→1, `r_switch` pulses 1 cycle, `w_core_busy`=2'b11 during SWITCH, then 2'b01 (hart 1 granted, `w_busy`=0).
- Quantum: `QUANTUM`=8, yield held high from cycle 0.
  - Required: no switch before `r_slice_cnt`=8; switch fires at count 8; counter is 0 after SWITCH.
  - DRAIN variant: yield withheld until cycle 20; state is DRAIN from cycle 8 and the switch fires at 20.
- Skip idle: `N_HARTS`=4, harts 1 and 2 inactive, sel=0, yield.
  - Required: sel→3; next yield wraps sel→0.
  - Only hart 0 active: no switch, `r_switch` stays 0.
- Lock and busy: yield on sel with `w_hart_lock`=1 for 5 cycles, then `w_busy`=1 for 3 cycles.
  - Required: switch occurs only on the first cycle where both are low; the request is not lost.
- Inactive current hart: hart 0 drops `w_hart_active` with no yield and no lock.
  - Required: switch to hart 1 within 1 cycle.
- Reset mid-switch: assert `RST` during SWITCH.
  - Required: sel=0, grant=1, `r_switch`=0, `r_slice_cnt`=0 on the next cycle.
  - Payload mux returns hart 0's bits (e.g. 128'hA5…).

Source files
------------

// File: rtl/hart_slot_arbiter.sv
// rtl/hart_slot_arbiter.sv - time-multiplexing arbiter sharing one memory/MMU port among harts
module hart_slot_arbiter #(
    parameter int N_HARTS   = 2,
    parameter int PAYLOAD_W = 128,
    parameter int QUANTUM   = 0,
    parameter int SKIP_IDLE = 1,
    localparam int SEL_W    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1,
    localparam int QW       = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [N_HARTS-1:0]             w_hart_active,
    input  logic [N_HARTS-1:0]             w_hart_yield,
    input  logic [N_HARTS-1:0]             w_hart_lock,
    input  logic                           w_busy,
    input  logic                           w_dram_busy,
    input  logic [N_HARTS*PAYLOAD_W-1:0]   w_hart_payload,
    output logic [PAYLOAD_W-1:0]           w_cluster_payload,
    output logic [N_HARTS-1:0]             w_core_busy,
    output logic [N_HARTS-1:0]             w_core_dram_busy,
    output logic [SEL_W-1:0]               r_hart_sel,
    output logic [N_HARTS-1:0]             r_grant,
    output logic                           r_switch,
    output logic [QW-1:0]                  r_slice_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [N_HARTS-1:0] grant_nxt;
    logic [QW-1:0]      cnt_nxt;
    logic [SEL_W-1:0]   nxt;
    logic [SEL_W-1:0]   idx;
    logic               nxt_valid;
    logic               slice_done;
    logic               eligible;
    logic               can_go;
    logic               fire;

    // Candidate successor: nearest active hart after the current one (cyclic), or plain +1
    always_comb begin
        nxt = r_hart_sel;
        idx = r_hart_sel;
        if (SKIP_IDLE != 0) begin
            // Walk from the farthest offset down so the nearest active hart wins
            for (int i = N_HARTS - 1; i >= 1; i--) begin
                idx = SEL_W'((int'(r_hart_sel) + i) % N_HARTS);
                if (w_hart_active[idx]) begin
                    nxt = idx;
                end
            end
        end else begin
            nxt = SEL_W'((int'(r_hart_sel) + 1) % N_HARTS);
        end
    end

    assign nxt_valid  = (nxt != r_hart_sel);
    assign slice_done = (QUANTUM == 0) || (r_slice_cnt >= QW'(QUANTUM));
    assign eligible   = w_hart_yield[r_hart_sel] && slice_done;
    assign can_go     = !w_hart_lock[r_hart_sel] && !w_busy && !w_dram_busy;
    // Lock and port-busy gate the switch; an inactive current hart forces one without a yield
    assign fire       = (eligible || !w_hart_active[r_hart_sel]) && can_go && nxt_valid;

    // Next-state, next-select and slice counter decisions
    always_comb begin
        state_nxt = state;
        sel_nxt   = r_hart_sel;
        cnt_nxt   = r_slice_cnt;
        case (state)
            ST_RUN, ST_DRAIN: begin
                if (fire) begin
                    sel_nxt   = nxt;
                    state_nxt = ST_SWITCH;
                    cnt_nxt   = '0;
                end else if (eligible && !nxt_valid) begin
                    // Nobody to hand over to: start a fresh slice on the same hart
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (QUANTUM > 0) begin
                    if (slice_done) begin
                        // Slice expired but switch not possible yet: wait, counter saturated
                        state_nxt = ST_DRAIN;
                    end else begin
                        cnt_nxt = r_slice_cnt + QW'(1);
                    end
                end
            end
            ST_SWITCH: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // One-hot grant tracks the select that will be registered
    always_comb begin
        grant_nxt = '0;
        for (int g = 0; g < N_HARTS; g++) begin
            grant_nxt[g] = (sel_nxt == SEL_W'(g));
        end
    end

    // State, select, grant and slice counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_RUN;
            r_hart_sel  <= '0;
            r_grant     <= N_HARTS'(1);
            r_slice_cnt <= '0;
        end else begin
            state       <= state_nxt;
            r_hart_sel  <= sel_nxt;
            r_grant     <= grant_nxt;
            r_slice_cnt <= cnt_nxt;
        end
    end

    assign r_switch = (state == ST_SWITCH);

    // Busy fan-out: only the granted hart sees the real port status, and nobody during the bubble
    always_comb begin
        w_core_busy      = '1;
        w_core_dram_busy = '1;
        for (int g = 0; g < N_HARTS; g++) begin
            if (state != ST_SWITCH && r_grant[g]) begin
                w_core_busy[g]      = w_busy;
                w_core_dram_busy[g] = w_dram_busy;
            end
        end
    end

    // Payload mux driven by the registered select only
    always_comb begin
        w_cluster_payload = '0;
        for (int g = 0; g < N_HARTS; g++) begin
            if (r_hart_sel == SEL_W'(g)) begin
                w_cluster_payload = w_hart_payload[g*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

endmodule

// File: tb/tb_hart_slot_arbiter.sv
// tb/tb_hart_slot_arbiter.sv - directed scoreboard bench for hart_slot_arbiter
module tb_hart_slot_arbiter;

    localparam logic [127:0] PAY0 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] PAY1 = 128'h5A5A_5A5A_1111_2222_3333_4444_5555_6666;

    logic clk;

    // DUT A: 2 harts, no quantum
    logic         a_rst, a_busy_in, a_dram_in;
    logic [1:0]   a_act, a_yld, a_lock;
    logic [255:0] a_pay;
    logic [127:0] a_cpay;
    logic [1:0]   a_busy, a_dbusy, a_grant;
    logic [0:0]   a_sel, a_cnt;
    logic         a_sw;

    // DUT Q: 2 harts, quantum 8
    logic         q_rst, q_busy_in, q_dram_in;
    logic [1:0]   q_act, q_yld, q_lock;
    logic [255:0] q_pay;
    logic [127:0] q_cpay;
    logic [1:0]   q_busy, q_dbusy, q_grant;
    logic [0:0]   q_sel;
    logic [3:0]   q_cnt;
    logic         q_sw;

    // DUT D: 4 harts, no quantum, skip idle
    logic         d_rst, d_busy_in, d_dram_in;
    logic [3:0]   d_act, d_yld, d_lock;
    logic [511:0] d_pay;
    logic [127:0] d_cpay;
    logic [3:0]   d_busy, d_dbusy, d_grant;
    logic [1:0]   d_sel;
    logic [0:0]   d_cnt;
    logic         d_sw;

    hart_slot_arbiter #(.N_HARTS(2), .PAYLOAD_W(128), .QUANTUM(0), .SKIP_IDLE(1)) u_a (
        .CLK(clk), .RST(a_rst), .w_hart_active(a_act), .w_hart_yield(a_yld),
        .w_hart_lock(a_lock), .w_busy(a_busy_in), .w_dram_busy(a_dram_in),
        .w_hart_payload(a_pay), .w_cluster_payload(a_cpay), .w_core_busy(a_busy),
        .w_core_dram_busy(a_dbusy), .r_hart_sel(a_sel), .r_grant(a_grant),
        .r_switch(a_sw), .r_slice_cnt(a_cnt)
    );

    hart_slot_arbiter #(.N_HARTS(2), .PAYLOAD_W(128), .QUANTUM(8), .SKIP_IDLE(1)) u_q (
        .CLK(clk), .RST(q_rst), .w_hart_active(q_act), .w_hart_yield(q_yld),
        .w_hart_lock(q_lock), .w_busy(q_busy_in), .w_dram_busy(q_dram_in),
        .w_hart_payload(q_pay), .w_cluster_payload(q_cpay), .w_core_busy(q_busy),
        .w_core_dram_busy(q_dbusy), .r_hart_sel(q_sel), .r_grant(q_grant),
        .r_switch(q_sw), .r_slice_cnt(q_cnt)
    );

    hart_slot_arbiter #(.N_HARTS(4), .PAYLOAD_W(128), .QUANTUM(0), .SKIP_IDLE(1)) u_d (
        .CLK(clk), .RST(d_rst), .w_hart_active(d_act), .w_hart_yield(d_yld),
        .w_hart_lock(d_lock), .w_busy(d_busy_in), .w_dram_busy(d_dram_in),
        .w_hart_payload(d_pay), .w_cluster_payload(d_cpay), .w_core_busy(d_busy),
        .w_core_dram_busy(d_dbusy), .r_hart_sel(d_sel), .r_grant(d_grant),
        .r_switch(d_sw), .r_slice_cnt(d_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           id;
        string        tag;
        logic [127:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [127:0] obs(input int id);
        case (id)
            1:  return 128'(a_sel);
            2:  return 128'(a_sw);
            3:  return 128'(a_busy);
            4:  return 128'(a_grant);
            5:  return 128'(a_cnt);
            6:  return a_cpay;
            11: return 128'(q_sel);
            12: return 128'(q_sw);
            15: return 128'(q_cnt);
            21: return 128'(d_sel);
            22: return 128'(d_sw);
            23: return 128'(d_busy);
            24: return 128'(d_grant);
            25: return 128'(d_dbusy);
            default: return 128'hDEAD;
        endcase
    endfunction

    task automatic push_exp(input int id, input string tag, input logic [127:0] val);
        exp_t e;
        e.id  = id;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t         e;
        logic [127:0] o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.id);
            n_cmp++;
            assert (o === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        a_rst = 1'b1; a_act = 2'b11; a_yld = 2'b00; a_lock = 2'b00;
        a_busy_in = 1'b0; a_dram_in = 1'b0; a_pay = {PAY1, PAY0};
        q_rst = 1'b1; q_act = 2'b11; q_yld = 2'b00; q_lock = 2'b00;
        q_busy_in = 1'b0; q_dram_in = 1'b0; q_pay = {PAY1, PAY0};
        d_rst = 1'b1; d_act = 4'b1111; d_yld = 4'b0000; d_lock = 4'b0000;
        d_busy_in = 1'b0; d_dram_in = 1'b0; d_pay = {PAY0, PAY1, PAY1, PAY0};

        // Reset state
        push_exp(1, "a_rst_sel", 128'd0);
        push_exp(4, "a_rst_grant", 128'b01);
        push_exp(2, "a_rst_sw", 128'd0);
        push_exp(5, "a_rst_cnt", 128'd0);
        push_exp(3, "a_rst_busy", 128'b10);
        push_exp(15, "q_rst_cnt", 128'd0);
        push_exp(24, "d_rst_grant", 128'b0001);
        push_exp(23, "d_rst_busy", 128'b1110);
        tick();

        // Basic round robin
        a_rst = 1'b0; a_yld = 2'b01;
        push_exp(1, "rr_sel", 128'd1);
        push_exp(2, "rr_sw", 128'd1);
        push_exp(3, "rr_busy_bubble", 128'b11);
        push_exp(4, "rr_grant", 128'b10);
        tick();
        a_yld = 2'b00;
        push_exp(1, "rr_sel_hold", 128'd1);
        push_exp(2, "rr_sw_clear", 128'd0);
        push_exp(3, "rr_busy_after", 128'b01);
        tick();

        // Lock then busy defer a held yield on hart 1
        a_yld = 2'b10; a_lock = 2'b10;
        for (int i = 0; i < 5; i++) begin
            push_exp(1, "lock_sel", 128'd1);
            push_exp(2, "lock_sw", 128'd0);
            tick();
        end
        a_lock = 2'b00; a_busy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1, "busy_sel", 128'd1);
            push_exp(2, "busy_sw", 128'd0);
            push_exp(3, "busy_core", 128'b11);
            tick();
        end
        a_busy_in = 1'b0;
        push_exp(1, "unblock_sel", 128'd0);
        push_exp(2, "unblock_sw", 128'd1);
        tick();
        a_yld = 2'b00;
        push_exp(2, "unblock_sw_clear", 128'd0);
        tick();

        // Inactive current hart switches away without a yield
        a_act = 2'b10;
        push_exp(1, "inact_sel", 128'd1);
        push_exp(2, "inact_sw", 128'd1);
        tick();
        a_act = 2'b11;
        push_exp(1, "inact_sel_hold", 128'd1);
        push_exp(2, "inact_sw_clear", 128'd0);
        tick();

        // Reset asserted during SWITCH
        a_yld = 2'b10;
        push_exp(1, "pre_sel0", 128'd0);
        tick();
        a_yld = 2'b00;
        tick();
        a_yld = 2'b01;
        push_exp(1, "mid_sw_sel", 128'd1);
        push_exp(2, "mid_sw_on", 128'd1);
        push_exp(6, "mid_sw_payload", PAY1);
        tick();
        a_rst = 1'b1; a_yld = 2'b00;
        push_exp(1, "rstsw_sel", 128'd0);
        push_exp(4, "rstsw_grant", 128'b01);
        push_exp(2, "rstsw_sw", 128'd0);
        push_exp(5, "rstsw_cnt", 128'd0);
        push_exp(6, "rstsw_payload", PAY0);
        tick();
        a_rst = 1'b0;

        // Quantum: yield held from the start, switch at count 8
        q_rst = 1'b0; q_yld = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            push_exp(15, "q_cnt_up", 128'(i));
            push_exp(11, "q_sel_hold", 128'd0);
            push_exp(12, "q_sw_none", 128'd0);
            tick();
        end
        push_exp(11, "q_fire_sel", 128'd1);
        push_exp(12, "q_fire_sw", 128'd1);
        push_exp(15, "q_fire_cnt", 128'd0);
        tick();
        q_yld = 2'b00;
        push_exp(12, "q_after_sw", 128'd0);
        push_exp(15, "q_after_cnt", 128'd0);
        tick();

        // Quantum DRAIN: yield withheld, counter saturates, switch when yield arrives
        for (int i = 1; i <= 12; i++) begin
            push_exp(15, "drain_cnt", 128'((i < 8) ? i : 8));
            push_exp(11, "drain_sel", 128'd1);
            push_exp(12, "drain_sw", 128'd0);
            tick();
        end
        q_yld = 2'b10;
        push_exp(11, "drain_fire_sel", 128'd0);
        push_exp(12, "drain_fire_sw", 128'd1);
        push_exp(15, "drain_fire_cnt", 128'd0);
        tick();
        q_yld = 2'b00;
        push_exp(12, "drain_sw_clear", 128'd0);
        tick();

        // Skip idle with 4 harts; DRAM busy defers first
        d_rst = 1'b0; d_act = 4'b1001; d_yld = 4'b0001; d_dram_in = 1'b1;
        push_exp(21, "skip_dram_sel", 128'd0);
        push_exp(22, "skip_dram_sw", 128'd0);
        push_exp(25, "skip_dram_core", 128'b1111);
        push_exp(23, "skip_busy_core", 128'b1110);
        tick();
        d_dram_in = 1'b0;
        push_exp(21, "skip_sel3", 128'd3);
        push_exp(22, "skip_sw", 128'd1);
        push_exp(24, "skip_grant", 128'b1000);
        tick();
        d_yld = 4'b0000;
        push_exp(22, "skip_sw_clear", 128'd0);
        push_exp(23, "skip_busy_h3", 128'b0111);
        tick();
        d_yld = 4'b1000;
        push_exp(21, "wrap_sel0", 128'd0);
        push_exp(22, "wrap_sw", 128'd1);
        tick();
        d_yld = 4'b0000;
        push_exp(22, "wrap_sw_clear", 128'd0);
        tick();
        d_act = 4'b0001; d_yld = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            push_exp(21, "alone_sel", 128'd0);
            push_exp(22, "alone_sw", 128'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
